// File: rtl/popcount24_unary_gen_pkg.sv
// Shared definitions for the popcount24 family: frame geometry and the
// state/mode encodings used by the unary frame generator.
package popcount_pkg;

    localparam int unsigned POP_N  = 24;
    localparam int unsigned POP_CW = 5;

    typedef enum logic {
        IDLE,
        EMIT
    } gen_state_t;

    typedef enum logic {
        MODE_THERM,
        MODE_SPREAD
    } gen_mode_t;

endpackage

// File: rtl/popcount24_unary_gen_if.sv
// Request/stream bundle of the unary frame generator. The master side is
// the generator itself; the slave side is the requester/consumer.
interface popcount24_unary_gen_if #(
    parameter int unsigned CW = popcount_pkg::POP_CW
);

    logic          s_valid;
    logic          s_ready;
    logic [CW-1:0] s_count;
    logic          s_mode;
    logic          m_valid;
    logic          m_ready;
    logic          m_bit;
    logic          m_last;
    logic          sat;

    modport master (
        input  s_valid, s_count, s_mode, m_ready,
        output s_ready, m_valid, m_bit, m_last, sat
    );

    modport slave (
        output s_valid, s_count, s_mode, m_ready,
        input  s_ready, m_valid, m_bit, m_last, sat
    );

endinterface

// File: rtl/popcount24_unary_gen_spread_step.sv
// One combinational Bresenham step: adds the count to the running
// accumulator and emits a one each time the sum wraps past N.
module unary_spread_step
    import popcount_pkg::*;
#(
    parameter int unsigned N  = POP_N,
    parameter int unsigned CW = POP_CW
) (
    input  logic [CW:0]   acc,
    input  logic [CW-1:0] c,
    output logic          step_bit,
    output logic [CW:0]   acc_next
);

    localparam logic [CW:0] N_W = (CW+1)'(N);

    logic [CW:0] t;

    // acc < N and c <= N, so t fits in CW+1 bits and stays below 2N.
    always_comb begin
        t        = acc + {1'b0, c};
        step_bit = (t >= N_W);
        acc_next = step_bit ? (t - N_W) : t;
    end

endmodule

// File: rtl/popcount24_unary_gen.sv
// Count-to-bitstream generator: turns a count into an N-bit unary frame,
// either thermometer (ones first) or evenly spread, one bit per beat.
module popcount24_unary_gen
    import popcount_pkg::*;
#(
    parameter int unsigned N  = POP_N,
    parameter int unsigned CW = POP_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    popcount24_unary_gen_if.master bus
);

    localparam logic [CW-1:0] N_C    = CW'(N);
    localparam logic [CW-1:0] LAST_I = CW'(N - 1);

    gen_state_t    state_q, state_d;
    gen_mode_t     mode_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx_q;
    logic [CW:0]   acc_q;
    logic          sat_q;
    logic          spread_bit;
    logic [CW:0]   acc_nxt;
    logic          accept;
    logic          beat;

    unary_spread_step #(
        .N  (N),
        .CW (CW)
    ) u_step (
        .acc      (acc_q),
        .c        (cnt_q),
        .step_bit (spread_bit),
        .acc_next (acc_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/bit outputs, decoded from registered state.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        beat        = 1'b0;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_bit   = 1'b0;
        bus.m_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    accept  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                bus.m_valid = 1'b1;
                bus.m_bit   = (mode_q == MODE_SPREAD) ? spread_bit : (idx_q < cnt_q);
                bus.m_last  = (idx_q == LAST_I);
                if (bus.m_ready) begin
                    beat = 1'b1;
                    if (bus.m_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture on accept; index/accumulator advance on each beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= MODE_THERM;
            sat_q  <= 1'b0;
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (accept) begin
            cnt_q  <= (bus.s_count > N_C) ? N_C : bus.s_count;
            mode_q <= gen_mode_t'(bus.s_mode);
            sat_q  <= (bus.s_count > N_C);
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (beat) begin
            idx_q  <= idx_q + CW'(1);
            acc_q  <= acc_nxt;
        end
    end

    assign bus.sat = sat_q;

endmodule

// File: tb/tb_popcount24_unary_gen.sv
// Self-checking bench for popcount24_unary_gen: constant frame table,
// reset/backpressure sequences, exhaustive and random frames against an
// arithmetic reference model.
module tb_popcount24_unary_gen;
    import popcount_pkg::*;

    localparam int N = 24;

    typedef struct {
        logic        mode;
        logic [4:0]  count;
        logic [23:0] exp_frame;
        logic        exp_sat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    popcount24_unary_gen_if #(.CW(5)) bus ();

    popcount24_unary_gen #(
        .N  (N),
        .CW (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Ones for frame bit j: thermometer puts them at j < c; spread places the
    // k-th one where j+1 first reaches k*N/c, i.e. floor((j+1)c/N) steps.
    function automatic logic [23:0] model_frame(input logic mode, input int count);
        logic [23:0] f;
        int c;
        c = (count > N) ? N : count;
        f = '0;
        for (int j = 0; j < N; j++) begin
            if (!mode) f[j] = (j < c);
            else       f[j] = (((j + 1) * c) / N) != ((j * c) / N);
        end
        return f;
    endfunction

    task automatic send_req(input logic mode, input logic [4:0] count);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("req_wait_ready", (waited < 100), 1);
        bus.s_valid = 1'b1;
        bus.s_count = count;
        bus.s_mode  = mode;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 right after the accept; consumes beats until m_last
    // (or max_beats), randomly stalling and scribbling on the request inputs.
    task automatic collect(input int pct, input int max_beats, input logic exp_sat,
                           output logic [23:0] frame, output int nbeats,
                           output int nlast, output int cycles);
        logic prev_stall, prev_bit, prev_last, done;
        int bad_sat, bad_stable, bad_ready;
        prev_stall = 0; prev_bit = 0; prev_last = 0; done = 0;
        bad_sat = 0; bad_stable = 0; bad_ready = 0;
        frame = '0; nbeats = 0; nlast = 0; cycles = 0;
        while (!done && cycles < 2000) begin
            bus.m_ready = ($urandom_range(99) < pct);
            bus.s_valid = (nbeats < N - 1);
            bus.s_count = 5'($urandom);
            bus.s_mode  = 1'($urandom);
            if (bus.m_valid === 1'b1) begin
                if (bus.sat !== exp_sat) bad_sat++;
                if (bus.s_ready !== 1'b0) bad_ready++;
                if (prev_stall && (bus.m_bit !== prev_bit || bus.m_last !== prev_last)) bad_stable++;
                prev_stall = !bus.m_ready;
                prev_bit   = bus.m_bit;
                prev_last  = bus.m_last;
                if (bus.m_ready) begin
                    if (nbeats < N) frame[nbeats] = bus.m_bit;
                    if (bus.m_last === 1'b1) nlast++;
                    nbeats++;
                    if (bus.m_last === 1'b1 || nbeats == max_beats) done = 1;
                end
            end else begin
                done = 1;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        check("sat_during_frame", bad_sat, 0);
        check("s_ready_low_in_frame", bad_ready, 0);
        check("stall_stability", bad_stable, 0);
    endtask

    task automatic run_frame(input string tag, input logic mode, input logic [4:0] count,
                             input int pct, input logic [23:0] exp, input logic exp_sat,
                             output logic [23:0] got);
        int nb, nl, cy;
        send_req(mode, count);
        collect(pct, 0, exp_sat, got, nb, nl, cy);
        check($sformatf("%s_frame", tag), got, exp);
        check($sformatf("%s_beats", tag), nb, N);
        check($sformatf("%s_last_once", tag), nl, 1);
        if (pct == 100) check($sformatf("%s_cycles", tag), cy, N);
        check($sformatf("%s_s_ready_after", tag), bus.s_ready, 1);
        check($sformatf("%s_m_valid_after", tag), bus.m_valid, 0);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [23:0] got, ref_f;
        int          nb, nl, cy;

        tbl[0] = '{1'b0, 5'd5,  24'h00001F, 1'b0};
        tbl[1] = '{1'b1, 5'd12, 24'hAAAAAA, 1'b0};
        tbl[2] = '{1'b1, 5'd0,  24'h000000, 1'b0};
        tbl[3] = '{1'b0, 5'd31, 24'hFFFFFF, 1'b1};
        tbl[4] = '{1'b0, 5'd3,  24'h000007, 1'b0};
        tbl[5] = '{1'b1, 5'd31, 24'hFFFFFF, 1'b1};
        tbl[6] = '{1'b1, 5'd3,  24'h808080, 1'b0};
        tbl[7] = '{1'b1, 5'd24, 24'hFFFFFF, 1'b0};
        tbl[8] = '{1'b1, 5'd1,  24'h800000, 1'b0};

        bus.s_valid = 1'b0;
        bus.s_count = '0;
        bus.s_mode  = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_bit",   bus.m_bit,   0);
        check("rst_m_last",  bus.m_last,  0);
        check("rst_sat",     bus.sat,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant table.
        foreach (tbl[k]) begin
            run_frame($sformatf("tbl%0d", k), tbl[k].mode, tbl[k].count, 100,
                      tbl[k].exp_frame, tbl[k].exp_sat, got);
        end

        // Backpressure: same spread-7 frame with and without stalls.
        begin
            logic [23:0] f_free;
            run_frame("spread7_free", 1'b1, 5'd7, 100, model_frame(1'b1, 7), 1'b0, f_free);
            run_frame("spread7_bp",   1'b1, 5'd7, 50,  model_frame(1'b1, 7), 1'b0, got);
            check("spread7_bp_vs_free", got, f_free);
        end

        // Reset in the middle of a saturated frame, after beat 10.
        send_req(1'b0, 5'd31);
        collect(100, 10, 1'b1, got, nb, nl, cy);
        check("mid_rst_beats", nb, 10);
        check("mid_rst_bits", got[9:0], 10'h3FF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_s_ready", bus.s_ready, 1);
        check("mid_rst_m_bit",   bus.m_bit,   0);
        check("mid_rst_m_last",  bus.m_last,  0);
        check("mid_rst_sat",     bus.sat,     0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst_therm3", 1'b0, 5'd3, 100, 24'h000007, 1'b0, got);

        // Exhaustive counts 0..24, both modes, popcount equals the count.
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c <= N; c++) begin
                run_frame($sformatf("exh_m%0d_c%0d", m, c), 1'(m), 5'(c), 100,
                          model_frame(1'(m), c), 1'b0, got);
                check($sformatf("exh_m%0d_c%0d_pop", m, c), $countones(got), c);
            end
        end

        // Random requests with random backpressure.
        for (int r = 0; r < 20; r++) begin
            logic       m;
            logic [4:0] c;
            int         pct;
            m     = 1'($urandom);
            c     = 5'($urandom_range(31));
            pct   = $urandom_range(100, 30);
            ref_f = model_frame(m, int'(c));
            run_frame($sformatf("rnd%0d_m%0d_c%0d", r, m, c), m, c, pct, ref_f, (c > 5'd24), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
